// File: rtl/soc_pkg.sv
// Shared types and helpers for the memory arbiter slice.
//   owner_t    : which requester owns the response slot in the next cycle
//   port_t     : requester identity, used for the last-grant record
//   GNT_I_BIT / GNT_D_BIT : bit positions inside the one-hot grant vector
//   word_index : byte address -> word index (low byte-lane bits dropped)
package soc_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } port_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned GNT_I_BIT  = 0;
  localparam int unsigned GNT_D_BIT  = 1;

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant policy for the I/D memory arbiter (purely combinational).
// Ports:
//   i_valid, d_valid : requester valids
//   burst_cnt        : consecutive D grants while I has been waiting
//   last_grant       : port that received the most recent grant
//   grant            : one-hot grant, bit GNT_I_BIT = I, bit GNT_D_BIT = D
// Build option: MEM_ARB_ROUND_ROBIN_EN selects alternating grants on
// contention; otherwise D has priority with a starvation guard for I.
module mem_arb_pick
  import soc_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             i_valid,
  input  logic             d_valid,
  input  logic [CNT_W-1:0] burst_cnt,
  input  port_t            last_grant,
  output logic [1:0]       grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic unused_burst;
  assign unused_burst = ^burst_cnt;
`else
  logic unused_last;
  assign unused_last = logic'(last_grant);
`endif

  always_comb begin
    grant = '0;
    if (i_valid && d_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_grant == GNT_D) grant[GNT_I_BIT] = 1'b1;
      else                     grant[GNT_D_BIT] = 1'b1;
`else
      if (burst_cnt == CNT_W'(MAX_D_BURST)) grant[GNT_I_BIT] = 1'b1;
      else                                  grant[GNT_D_BIT] = 1'b1;
`endif
    end else if (i_valid) begin
      grant[GNT_I_BIT] = 1'b1;
    end else if (d_valid) begin
      grant[GNT_D_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch (I)
// and load/store (D) ports. One access per cycle; the 1-cycle read response
// is routed back to the port that was granted in the previous cycle.
// Ports:
//   clk, resetn                    : clock, async active-low reset
//   i_valid/i_addr/i_ready         : fetch request channel
//   i_rdata/i_rvalid               : fetch response
//   d_valid/d_addr/d_wstrb/d_wdata : load/store request (wstrb 0 = read)
//   d_ready, d_rdata/d_rvalid      : D accept and response (reads and write acks)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM interface
// Build option: MEM_ARB_ROUND_ROBIN_EN (policy handled in mem_arb_pick).
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_valid,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_ready,
  output logic [DATA_W-1:0]            i_rdata,
  output logic                         i_rvalid,
  input  logic                         d_valid,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [3:0]                   d_wstrb,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_ready,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_rvalid,
  output logic                         mem_en,
  output logic [3:0]                   mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_D_BURST + 1);

  owner_t           owner, owner_nxt;
  port_t            last_grant;
  logic [CNT_W-1:0] burst_cnt;
  logic [1:0]       pick;
  logic [1:0]       gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [31:0]      widx;
  logic             unused_idx;

  mem_arb_pick #(
    .MAX_D_BURST (MAX_D_BURST),
    .CNT_W       (CNT_W)
  ) u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .burst_cnt  (burst_cnt),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // No accepts while reset is held.
  assign gnt     = pick & {2{resetn}};
  assign i_ready = gnt[GNT_I_BIT];
  assign d_ready = gnt[GNT_D_BIT];

  // Upper address bits beyond the RAM depth are dropped, so addresses wrap.
  assign gnt_addr   = gnt[GNT_D_BIT] ? d_addr : i_addr;
  assign widx       = word_index(32'(gnt_addr));
  assign unused_idx = ^widx;

  always_comb begin
    mem_en    = |gnt;
    mem_we    = '0;
    mem_wdata = '0;
    mem_addr  = widx[AW-1:0];
    owner_nxt = OWN_NONE;
    if (gnt[GNT_D_BIT]) begin
      mem_we    = d_wstrb;
      mem_wdata = d_wdata;
      owner_nxt = OWN_D;
    end else if (gnt[GNT_I_BIT]) begin
      owner_nxt = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= OWN_NONE;
      burst_cnt  <= '0;
      last_grant <= GNT_I;
    end else begin
      owner <= owner_nxt;
      if (!i_valid || gnt[GNT_I_BIT])
        burst_cnt <= '0;
      else if (gnt[GNT_D_BIT] && burst_cnt != CNT_W'(MAX_D_BURST))
        burst_cnt <= burst_cnt + CNT_W'(1);
      if (|gnt)
        last_grant <= gnt[GNT_D_BIT] ? GNT_D : GNT_I;
    end
  end

  assign i_rvalid = (owner == OWN_I);
  assign d_rvalid = (owner == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import soc_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        d_valid = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_WORDS   (1024),
    .MAX_D_BURST (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .d_valid   (d_valid),
    .d_addr    (d_addr),
    .d_wstrb   (d_wstrb),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .d_rvalid  (d_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Byte-enabled single-port RAM model, read data one cycle after mem_en.
  logic [31:0] ram [1024];
  logic        preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      ram[2] <= 32'h0BADF00D;
      ram[4] <= 32'hDEADBEEF;
      ram[8] <= 32'h11223344;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        eir;
    logic        edr;
    logic        een;
    logic [3:0]  ewe;
    logic [9:0]  ema;
    logic        eirv;
    logic        edrv;
    logic        erd_chk;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic [31:0] ia,
    input logic dv, input logic [31:0] da, input logic [3:0] ws, input logic [31:0] wd,
    input logic eir, input logic edr, input logic een, input logic [3:0] ewe,
    input logic [9:0] ema, input logic eirv, input logic edrv,
    input logic erd_chk, input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.ws = ws; v.wd = wd;
    v.eir = eir; v.edr = edr; v.een = een; v.ewe = ewe; v.ema = ema;
    v.eirv = eirv; v.edrv = edrv; v.erd_chk = erd_chk; v.erd = erd;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da, input logic [3:0] ws,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    resetn  = rst;
    i_valid = iv;
    i_addr  = ia;
    d_valid = dv;
    d_addr  = da;
    d_wstrb = ws;
    d_wdata = wd;
  endtask

  vec_t vt [14];

  task automatic run_seq(input string tag, input string pat, input string ivp);
    logic [7:0] got;
    logic [7:0] prev;
    prev = "-";
    for (int k = 0; k < pat.len(); k++) begin
      drive(1'b1, ivp[k] == "1", 32'h10, 1'b1, 32'h20, 4'h0, 32'h0);
      @(negedge clk);
      got = d_ready ? "D" : (i_ready ? "I" : "-");
      chk({tag, " grant"}, {24'h0, got}, {24'h0, pat[k]});
      chk({tag, " mem_en"}, {31'h0, mem_en}, 32'h1);
      chk({tag, " one ready"}, {30'h0, i_ready, d_ready} & {30'h0, i_ready, d_ready} & 32'h3,
          (pat[k] == "D") ? 32'h1 : 32'h2);
      if (k > 0) begin
        chk({tag, " d_rvalid"}, {31'h0, d_rvalid}, {31'h0, prev == "D"});
        chk({tag, " i_rvalid"}, {31'h0, i_rvalid}, {31'h0, prev == "I"});
      end
      prev = pat[k];
    end
  endtask

  initial begin
    //         rst iv ia          dv da          ws    wd            eir edr een ewe   ema eirv edrv rchk erd
    vt[0]  = mk(0, 1, 32'h10,     1, 32'h20,     4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  0,   0,   0,   32'h0);
    vt[1]  = mk(1, 1, 32'h10,     1, 32'h20,     4'h0, 32'h0,        0,  1,  1,  4'h0, 8,  0,   0,   0,   32'h0);
    vt[2]  = mk(1, 0, 32'h0,      0, 32'h0,      4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  0,   1,   1,   32'h11223344);
    vt[3]  = mk(1, 1, 32'h10,     0, 32'h0,      4'h0, 32'h0,        1,  0,  1,  4'h0, 4,  0,   0,   0,   32'h0);
    vt[4]  = mk(1, 0, 32'h0,      0, 32'h0,      4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  1,   0,   1,   32'hDEADBEEF);
    vt[5]  = mk(1, 0, 32'h0,      1, 32'h20,     4'h3, 32'hAABBCCDD, 0,  1,  1,  4'h3, 8,  0,   0,   0,   32'h0);
    vt[6]  = mk(1, 0, 32'h0,      1, 32'h20,     4'h0, 32'h0,        0,  1,  1,  4'h0, 8,  0,   1,   0,   32'h0);
    vt[7]  = mk(1, 0, 32'h0,      0, 32'h0,      4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  0,   1,   1,   32'h1122CCDD);
    vt[8]  = mk(1, 1, 32'h1008,   0, 32'h0,      4'h0, 32'h0,        1,  0,  1,  4'h0, 2,  0,   0,   0,   32'h0);
    vt[9]  = mk(1, 0, 32'h0,      0, 32'h0,      4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  1,   0,   1,   32'h0BADF00D);
    vt[10] = mk(1, 0, 32'h0,      1, 32'h10,     4'h0, 32'h0,        0,  1,  1,  4'h0, 4,  0,   0,   0,   32'h0);
    vt[11] = mk(0, 0, 32'h0,      0, 32'h0,      4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  0,   0,   0,   32'h0);
    vt[12] = mk(1, 1, 32'h10,     1, 32'h20,     4'h0, 32'h0,        0,  1,  1,  4'h0, 8,  0,   0,   0,   32'h0);
    vt[13] = mk(1, 0, 32'h0,      0, 32'h0,      4'h0, 32'h0,        0,  0,  0,  4'h0, 0,  0,   1,   1,   32'h1122CCDD);

    for (int k = 0; k < 14; k++) begin
      drive(vt[k].rst, vt[k].iv, vt[k].ia, vt[k].dv, vt[k].da, vt[k].ws, vt[k].wd);
      if (k == 0) preload = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d i_ready", k), {31'h0, i_ready}, {31'h0, vt[k].eir});
      chk($sformatf("v%0d d_ready", k), {31'h0, d_ready}, {31'h0, vt[k].edr});
      chk($sformatf("v%0d mem_en", k), {31'h0, mem_en}, {31'h0, vt[k].een});
      chk($sformatf("v%0d mem_we", k), {28'h0, mem_we}, {28'h0, vt[k].ewe});
      chk($sformatf("v%0d i_rvalid", k), {31'h0, i_rvalid}, {31'h0, vt[k].eirv});
      chk($sformatf("v%0d d_rvalid", k), {31'h0, d_rvalid}, {31'h0, vt[k].edrv});
      if (vt[k].een)
        chk($sformatf("v%0d mem_addr", k), {22'h0, mem_addr}, {22'h0, vt[k].ema});
      if (vt[k].ewe != 4'h0)
        chk($sformatf("v%0d mem_wdata", k), mem_wdata, vt[k].wd);
      if (vt[k].erd_chk)
        chk($sformatf("v%0d rdata", k), vt[k].eirv ? i_rdata : d_rdata, vt[k].erd);
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    run_seq("burst", "IDIDIDIDID", "1111111111");
    run_seq("clear", "IDDIDIDI",   "11011111");
`else
    run_seq("burst", "DDDDIDDDDI", "1111111111");
    run_seq("clear", "DDDDDDDI",   "11011111");
`endif

    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("tail i_rvalid", {31'h0, i_rvalid}, 32'h1);
    chk("tail mem_en", {31'h0, mem_en}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous block RAM between the CPU instruction-fetch port (I) and load/store port (D).
- Sits between the Cpu core and program/data memory inside soc.
- Issues at most one memory access per cycle and routes each 1-cycle-latency read response back to its requester.
- Default policy is fixed priority to D, with a starvation guard for I.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports
- DATA_W, 32, data word width (fixed 32; byte strobes assume 4 lanes)
- MEM_WORDS, 1024, RAM depth in words (power of 2)
- MAX_D_BURST, 4, max consecutive D grants while I is waiting before I is forced

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- i_valid  in  1  fetch request
- i_addr  in  ADDR_W  fetch byte address
- i_ready  out  1  fetch request accepted this cycle
- i_rdata  out  DATA_W  fetch data
- i_rvalid  out  1  i_rdata valid
- d_valid  in  1  load/store request
- d_addr  in  ADDR_W  load/store byte address
- d_wstrb  in  4  byte write strobes; 0 = read
- d_wdata  in  DATA_W  store data
- d_ready  out  1  D request accepted this cycle
- d_rdata  out  DATA_W  load data
- d_rvalid  out  1  D response (read data or write ack)
- mem_en  out  1  RAM enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  $clog2(MEM_WORDS)  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en

Behaviour:
- Handshake: a requester holds valid, addr, wstrb and wdata stable until ready. Transfer happens on a cycle with valid & ready.
- i_ready and d_ready are combinational from valid and the grant decision; at most one is high per cycle.
- Grant rules:
  - Only one valid: that port is granted.
  - Both valid: D is granted, unless burst_cnt == MAX_D_BURST, in which case I is granted.
- burst_cnt:
  - Increments on each D grant while i_valid is high, saturating at MAX_D_BURST.
  - Clears on any I grant, or on any cycle with i_valid low.
- Memory side (same cycle as the grant): mem_en = 1, mem_addr = granted addr[2 +: log2(MEM_WORDS)], with upper bits ignored (address wraps) and addr[1:0] ignored.
  - I grant: mem_we = 0.
  - D grant: mem_we = d_wstrb, mem_wdata = d_wdata.
  - No grant: mem_en = 0, mem_we = 0.
- Response: registered owner (NONE/I/D) set on the grant cycle. Next cycle:
  - Owner I: i_rvalid = 1.
  - Owner D: d_rvalid = 1, for both reads and writes.
  - i_rdata and d_rdata both driven from mem_rdata; content is meaningful only when the matching rvalid is high.
- Throughput: back-to-back grants every cycle. Latency is 1 cycle from accept to rvalid. No backpressure on responses; requesters always sink them.
- Read during write to the same word in consecutive cycles returns the newly written data, since the RAM is write-first-free and the accesses are sequential.
- Reset (async assert, sync release):
  - owner = NONE, i_rvalid = 0, d_rvalid = 0, burst_cnt = 0, last_grant = I.
  - Readies low while resetn = 0.
  - An in-flight response at reset assertion is dropped.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined: when both requesters are valid, grant goes to the port not in last_grant. last_grant updates on every grant. burst_cnt and MAX_D_BURST are unused.
- Not defined: fixed D priority with the starvation guard described above.

Decomposition:
- soc_pkg holds:
  - owner enum: OWN_NONE, OWN_I, OWN_D
  - WORD_BYTES = 4
  - function for word-index extraction
- One combinational sub-module, mem_arb_pick: inputs i_valid, d_valid, burst_cnt and last_grant; outputs one-hot grant. The policy macro is confined to this sub-module.
- mem_arbiter keeps the registers and the memory mux.

Test Plan:
- Reset with both valids high -> readies 0, rvalids 0. First cycle after release, D granted; mem_en = 1; d_rvalid = 1 next cycle.
- I only, i_addr = 0x10, RAM[4] = 0xDEADBEEF -> i_ready same cycle, mem_addr = 4, i_rvalid = 1 with i_rdata = 0xDEADBEEF one cycle later.
- D store d_addr = 0x20, wstrb = 0b0011, wdata = 0xAABBCCDD over old 0x11223344, then D load of 0x20 -> mem_we = 0011, d_rvalid ack, load returns 0x1122CCDD.
- Both valid continuously, fixed mode, MAX_D_BURST = 4 -> grant sequence D,D,D,D,I,D,D,D,D,I. Under MEM_ARB_ROUND_ROBIN_EN -> D,I,D,I,...
- Address wrap: i_addr = MEM_WORDS*4 + 8 -> mem_addr = 2.
- resetn pulsed low the cycle after a D grant -> d_rvalid stays 0. After release, the next grant behaves normally with burst_cnt = 0.
